mux_nx1_tmr: RTL and testbench

- Registered N:1 data selector for the fault-tolerant ALU datapath; successor to the single-bit 2:1 mux.
- Select arrives as three redundant copies, which are majority-voted per bit.
- Output is held in a one-entry valid/ready pipeline register.
- Select disagreements are counted and flagged for the ALU fault monitor.

---
 rtl/ft_alu_pkg.sv | 40 ++++
 rtl/mux_nx1_tmr_if.sv | 28 ++
 rtl/tmr_sel_voter.sv | 29 ++
 rtl/mux_nx1_tmr.sv | 80 ++++++++
 tb/tb_mux_nx1_tmr.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ft_alu_pkg.sv
// Shared helpers for the fault-tolerant ALU: TMR majority and select classification.
// No ports; imported by the select voter and, later, by the ALU datapath voters.
package ft_alu_pkg;

  localparam int unsigned VEC_W = 32;

  typedef enum logic [1:0] {
    SEL_OK     = 2'd0,
    SEL_CORR   = 2'd1,
    SEL_UNCORR = 2'd2
  } sel_class_e;

  function automatic logic [VEC_W-1:0] maj3(
    input logic [VEC_W-1:0] a,
    input logic [VEC_W-1:0] b,
    input logic [VEC_W-1:0] c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Callers zero-extend narrower selects, so the unused upper
  // bits agree across copies and never create a mismatch.
  function automatic sel_class_e sel_class(
    input logic [VEC_W-1:0] a,
    input logic [VEC_W-1:0] b,
    input logic [VEC_W-1:0] c,
    input int unsigned      n_in
  );
    logic [VEC_W-1:0] v;
    logic             mis;
    logic             unc;
    v   = maj3(a, b, c);
    mis = (a != b) || (a != c);
    unc = ((a != b) && (a != c) && (b != c)) || (v >= n_in);
    if (unc)      return SEL_UNCORR;
    else if (mis) return SEL_CORR;
    else          return SEL_OK;
  endfunction

endpackage

// File: rtl/mux_nx1_tmr_if.sv
// Data/select/handshake bundle of the TMR selector.
// master drives IN_DATA, SEL_A/B/C, IN_VALID, OUT_READY; slave drives the rest.
interface mux_nx1_tmr_if #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4
);
  localparam int SEL_W = $clog2(N_IN);

  logic [N_IN*WIDTH-1:0] IN_DATA;
  logic [SEL_W-1:0]      SEL_A;
  logic [SEL_W-1:0]      SEL_B;
  logic [SEL_W-1:0]      SEL_C;
  logic                  IN_VALID;
  logic                  IN_READY;
  logic [WIDTH-1:0]      OUT_DATA;
  logic                  OUT_VALID;
  logic                  OUT_READY;

  modport master (
    output IN_DATA, SEL_A, SEL_B, SEL_C, IN_VALID, OUT_READY,
    input  IN_READY, OUT_DATA, OUT_VALID
  );

  modport slave (
    input  IN_DATA, SEL_A, SEL_B, SEL_C, IN_VALID, OUT_READY,
    output IN_READY, OUT_DATA, OUT_VALID
  );
endinterface

// File: rtl/tmr_sel_voter.sv
// Combinational majority vote of three select copies plus fault classification.
// Ports: sel_a/b/c in, vsel voted select, corr/uncorr classification out.
module tmr_sel_voter
  import ft_alu_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int N_IN  = 4
) (
  input  logic [SEL_W-1:0] sel_a,
  input  logic [SEL_W-1:0] sel_b,
  input  logic [SEL_W-1:0] sel_c,
  output logic [SEL_W-1:0] vsel,
  output logic             corr,
  output logic             uncorr
);
  localparam int unsigned NI = N_IN;

  logic [VEC_W-1:0] a, b, c;
  sel_class_e       cls;

  assign a = VEC_W'(sel_a);
  assign b = VEC_W'(sel_b);
  assign c = VEC_W'(sel_c);

  assign vsel   = SEL_W'(maj3(a, b, c));
  assign cls    = sel_class(a, b, c, NI);
  assign corr   = (cls == SEL_CORR);
  assign uncorr = (cls == SEL_UNCORR);
endmodule

// File: rtl/mux_nx1_tmr.sv
// Registered N:1 selector with TMR-voted select and a one-entry valid/ready stage.
// Ports: CLK, RST (async high), bus (slave), CLR_FAULT, FAULT, UNCORR, FAULT_CNT.
module mux_nx1_tmr
  import ft_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  mux_nx1_tmr_if.slave     bus,
  input  logic             CLR_FAULT,
  output logic             FAULT,
  output logic             UNCORR,
  output logic [CNT_W-1:0] FAULT_CNT
);
  localparam int SEL_W = $clog2(N_IN);

  logic [SEL_W-1:0] vsel;
  logic             corr;
  logic             uncorr;
  logic [WIDTH-1:0] sel_data;
  logic             accept;
  logic             log_ev;

  tmr_sel_voter #(
    .SEL_W (SEL_W),
    .N_IN  (N_IN)
  ) u_voter (
    .sel_a  (bus.SEL_A),
    .sel_b  (bus.SEL_B),
    .sel_c  (bus.SEL_C),
    .vsel   (vsel),
    .corr   (corr),
    .uncorr (uncorr)
  );

  // Loop decode keeps out-of-range selects from indexing past IN_DATA.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (vsel == SEL_W'(k)) sel_data = bus.IN_DATA[k*WIDTH +: WIDTH];
    end
  end

  assign bus.IN_READY = !bus.OUT_VALID || bus.OUT_READY;
  assign accept       = bus.IN_VALID && bus.IN_READY;
  assign log_ev       = accept && (corr || uncorr);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.OUT_DATA  <= '0;
      bus.OUT_VALID <= 1'b0;
    end else if (accept) begin
      bus.OUT_DATA  <= uncorr ? '0 : sel_data;
      bus.OUT_VALID <= 1'b1;
    end else if (bus.OUT_READY) begin
      bus.OUT_VALID <= 1'b0;
    end
  end

  // A clear coinciding with a logged event keeps only that event.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FAULT     <= 1'b0;
      UNCORR    <= 1'b0;
      FAULT_CNT <= '0;
    end else if (log_ev) begin
      FAULT  <= corr || (FAULT && !CLR_FAULT);
      UNCORR <= uncorr || (UNCORR && !CLR_FAULT);
      if (CLR_FAULT)       FAULT_CNT <= CNT_W'(1);
      else if (!(&FAULT_CNT)) FAULT_CNT <= FAULT_CNT + CNT_W'(1);
    end else if (CLR_FAULT) begin
      FAULT     <= 1'b0;
      UNCORR    <= 1'b0;
      FAULT_CNT <= '0;
    end
  end
endmodule

// File: tb/tb_mux_nx1_tmr.sv
// Directed self-checking bench for mux_nx1_tmr.
// Three instances: default, N_IN=3, CNT_W=2.
module tb_mux_nx1_tmr;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  mux_nx1_tmr_if #(.WIDTH(8), .N_IN(4)) b0 ();
  mux_nx1_tmr_if #(.WIDTH(8), .N_IN(3)) b1 ();
  mux_nx1_tmr_if #(.WIDTH(8), .N_IN(4)) b2 ();

  logic       clr0, clr1, clr2;
  logic       f0, f1, f2, u0f, u1f, u2f;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  mux_nx1_tmr #(.WIDTH(8), .N_IN(4), .CNT_W(8)) u0 (
    .CLK(CLK), .RST(RST), .bus(b0), .CLR_FAULT(clr0),
    .FAULT(f0), .UNCORR(u0f), .FAULT_CNT(c0));
  mux_nx1_tmr #(.WIDTH(8), .N_IN(3), .CNT_W(8)) u1 (
    .CLK(CLK), .RST(RST), .bus(b1), .CLR_FAULT(clr1),
    .FAULT(f1), .UNCORR(u1f), .FAULT_CNT(c1));
  mux_nx1_tmr #(.WIDTH(8), .N_IN(4), .CNT_W(2)) u2 (
    .CLK(CLK), .RST(RST), .bus(b2), .CLR_FAULT(clr2),
    .FAULT(f2), .UNCORR(u2f), .FAULT_CNT(c2));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sel0(input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] c);
    b0.SEL_A = a; b0.SEL_B = b; b0.SEL_C = c;
  endtask

  task automatic sel2(input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] c);
    b2.SEL_A = a; b2.SEL_B = b; b2.SEL_C = c;
  endtask

  initial begin
    b0.IN_DATA = 32'h44332211; sel0(2'd0, 2'd0, 2'd0);
    b0.IN_VALID = 1'b0; b0.OUT_READY = 1'b1; clr0 = 1'b0;
    b1.IN_DATA = 24'h332211;
    b1.SEL_A = 2'd0; b1.SEL_B = 2'd0; b1.SEL_C = 2'd0;
    b1.IN_VALID = 1'b0; b1.OUT_READY = 1'b1; clr1 = 1'b0;
    b2.IN_DATA = 32'h44332211; sel2(2'd0, 2'd0, 2'd0);
    b2.IN_VALID = 1'b0; b2.OUT_READY = 1'b1; clr2 = 1'b0;

    step();
    check("rst_data", 32'(b0.OUT_DATA), 32'h0);
    check("rst_valid", 32'(b0.OUT_VALID), 32'h0);
    check("rst_fault", 32'(f0), 32'h0);
    check("rst_cnt", 32'(c0), 32'h0);
    RST = 1'b0;
    #1;
    check("rdy_idle", 32'(b0.IN_READY), 32'h1);

    // Clean select.
    sel0(2'd2, 2'd2, 2'd2); b0.IN_VALID = 1'b1;
    step();
    check("ok_data", 32'(b0.OUT_DATA), 32'h33);
    check("ok_valid", 32'(b0.OUT_VALID), 32'h1);
    check("ok_fault", 32'(f0), 32'h0);
    check("ok_cnt", 32'(c0), 32'h0);

    // Correctable: 1,1,3 votes 1.
    sel0(2'd1, 2'd1, 2'd3);
    step();
    check("corr_data", 32'(b0.OUT_DATA), 32'h22);
    check("corr_fault", 32'(f0), 32'h1);
    check("corr_unc", 32'(u0f), 32'h0);
    check("corr_cnt", 32'(c0), 32'h1);

    // Uncorrectable: all differ.
    sel0(2'd0, 2'd1, 2'd2);
    step();
    check("unc_data", 32'(b0.OUT_DATA), 32'h0);
    check("unc_flag", 32'(u0f), 32'h1);
    check("unc_cnt", 32'(c0), 32'h2);

    // Drain, then backpressure.
    b0.IN_VALID = 1'b0;
    step();
    check("drain_valid", 32'(b0.OUT_VALID), 32'h0);
    sel0(2'd0, 2'd0, 2'd0);
    b0.IN_VALID = 1'b1; b0.OUT_READY = 1'b0;
    b0.IN_DATA = 32'h443322A0;
    step();
    check("bp_first", 32'(b0.OUT_DATA), 32'hA0);
    sel0(2'd0, 2'd0, 2'd1);
    for (int i = 1; i <= 5; i++) begin
      b0.IN_DATA = {24'h443322, 8'(8'hA0 + i)};
      #1;
      check("bp_rdy", 32'(b0.IN_READY), 32'h0);
      step();
      check("bp_hold", 32'(b0.OUT_DATA), 32'hA0);
      check("bp_valid", 32'(b0.OUT_VALID), 32'h1);
    end
    check("bp_nolog", 32'(c0), 32'h2);

    // Release: one transfer per cycle.
    sel0(2'd0, 2'd0, 2'd0);
    b0.OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b0.IN_DATA = {24'h443322, 8'(8'hB0 + i)};
      #1;
      check("bb_rdy", 32'(b0.IN_READY), 32'h1);
      step();
      check("bb_data", 32'(b0.OUT_DATA), 32'(8'hB0 + i));
      check("bb_valid", 32'(b0.OUT_VALID), 32'h1);
    end
    b0.IN_VALID = 1'b0;
    step();
    check("bb_end_valid", 32'(b0.OUT_VALID), 32'h0);
    check("bb_end_data", 32'(b0.OUT_DATA), 32'hB2);

    // Clear alone.
    clr0 = 1'b1;
    step();
    clr0 = 1'b0;
    check("clr_fault", 32'(f0), 32'h0);
    check("clr_unc", 32'(u0f), 32'h0);
    check("clr_cnt", 32'(c0), 32'h0);

    // Out-of-range vote with N_IN=3.
    b1.SEL_A = 2'd3; b1.SEL_B = 2'd3; b1.SEL_C = 2'd3;
    b1.IN_VALID = 1'b1;
    step();
    b1.IN_VALID = 1'b0;
    check("n3_data", 32'(b1.OUT_DATA), 32'h0);
    check("n3_valid", 32'(b1.OUT_VALID), 32'h1);
    check("n3_unc", 32'(u1f), 32'h1);
    check("n3_fault", 32'(f1), 32'h0);
    check("n3_cnt", 32'(c1), 32'h1);

    // Saturation with CNT_W=2.
    sel2(2'd1, 2'd1, 2'd3); b2.IN_VALID = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("sat_cnt", 32'(c2), 32'(i > 3 ? 3 : i));
    end
    b2.IN_VALID = 1'b0;
    clr2 = 1'b1;
    step();
    clr2 = 1'b0;
    check("sat_clr", 32'(c2), 32'h0);
    check("sat_clr_f", 32'(f2), 32'h0);
    sel2(2'd0, 2'd1, 2'd2); b2.IN_VALID = 1'b1;
    step();
    check("pre_unc", 32'(u2f), 32'h1);
    sel2(2'd1, 2'd1, 2'd3); clr2 = 1'b1;
    step();
    clr2 = 1'b0; b2.IN_VALID = 1'b0;
    check("clrev_fault", 32'(f2), 32'h1);
    check("clrev_unc", 32'(u2f), 32'h0);
    check("clrev_cnt", 32'(c2), 32'h1);
    check("clrev_data", 32'(b2.OUT_DATA), 32'h22);

    // Async reset mid-cycle with a pending output.
    b0.IN_DATA = 32'h44332211;
    sel0(2'd3, 2'd3, 2'd1);
    b0.IN_VALID = 1'b1; b0.OUT_READY = 1'b0;
    step();
    check("ar_pre_data", 32'(b0.OUT_DATA), 32'h44);
    check("ar_pre_cnt", 32'(c0), 32'h1);
    #2;
    RST = 1'b1;
    #1;
    check("ar_valid", 32'(b0.OUT_VALID), 32'h0);
    check("ar_data", 32'(b0.OUT_DATA), 32'h0);
    check("ar_fault", 32'(f0), 32'h0);
    check("ar_cnt", 32'(c0), 32'h0);
    step();
    RST = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
